// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: T-state encoding, opcodes, control-word bit positions
// and the per-step control words the sequencer emits.
package sap_pkg;

  localparam int OP_W = 4;
  localparam int CW_W = 12;

  localparam int CP_BIT   = 11;
  localparam int EP_BIT   = 10;
  localparam int LM_N_BIT = 9;
  localparam int CE_N_BIT = 8;
  localparam int L1_N_BIT = 7;
  localparam int E1_N_BIT = 6;
  localparam int LA_N_BIT = 5;
  localparam int EA_BIT   = 4;
  localparam int SU_BIT   = 3;
  localparam int EU_BIT   = 2;
  localparam int LB_N_BIT = 1;
  localparam int LO_N_BIT = 0;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } STATE_t;

  typedef enum logic [OP_W-1:0] {
    LDA = 4'b0000,
    ADD = 4'b0001,
    SUB = 4'b0010,
    OUT = 4'b1110,
    HLT = 4'b1111
  } OPCODE_t;

  function automatic logic [CW_W-1:0] cw_bit(input int b);
    return CW_W'(1) << b;
  endfunction

  localparam logic [CW_W-1:0] CW_NOP = cw_bit(LM_N_BIT) | cw_bit(CE_N_BIT) |
                                       cw_bit(L1_N_BIT) | cw_bit(E1_N_BIT) |
                                       cw_bit(LA_N_BIT) | cw_bit(LB_N_BIT) |
                                       cw_bit(LO_N_BIT);

  // Each step toggles its signals away from the idle word, so active-low bits
  // drop and active-high bits rise with the same XOR.
  localparam logic [CW_W-1:0] CW_FETCH1 = CW_NOP ^ cw_bit(EP_BIT) ^ cw_bit(LM_N_BIT);
  localparam logic [CW_W-1:0] CW_FETCH2 = CW_NOP ^ cw_bit(CP_BIT);
  localparam logic [CW_W-1:0] CW_FETCH3 = CW_NOP ^ cw_bit(CE_N_BIT) ^ cw_bit(L1_N_BIT);
  localparam logic [CW_W-1:0] CW_LDA4   = CW_NOP ^ cw_bit(LM_N_BIT) ^ cw_bit(E1_N_BIT);
  localparam logic [CW_W-1:0] CW_LDA5   = CW_NOP ^ cw_bit(CE_N_BIT) ^ cw_bit(LA_N_BIT);
  localparam logic [CW_W-1:0] CW_ADD5   = CW_NOP ^ cw_bit(CE_N_BIT) ^ cw_bit(LB_N_BIT);
  localparam logic [CW_W-1:0] CW_ADD6   = CW_NOP ^ cw_bit(EU_BIT) ^ cw_bit(LA_N_BIT);
  localparam logic [CW_W-1:0] CW_SUB6   = CW_ADD6 ^ cw_bit(SU_BIT);
  localparam logic [CW_W-1:0] CW_OUT4   = CW_NOP ^ cw_bit(EA_BIT) ^ cw_bit(LO_N_BIT);

endpackage

// File: rtl/sap_ring_counter.sv
// Six-step one-hot T-state ring, advanced on the falling clock edge so the
// control word is stable around every rising edge the datapath samples on.
//
// state | meaning
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR
// T4-T6 | execute steps decoded from the opcode
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   freeze,
  output STATE_t state
);

  // Any pattern that is not a single legal bit falls back to T1.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= T1;
    end else begin
      case (state)
        T1:      if (!freeze) state <= T2;
        T2:      if (!freeze) state <= T3;
        T3:      if (!freeze) state <= T4;
        T4:      if (!freeze) state <= T5;
        T5:      if (!freeze) state <= T6;
        T6:      if (!freeze) state <= T1;
        default: state <= T1;
      endcase
    end
  end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter, opcode decoder and halt flag
// producing the 12-bit control word for the datapath.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int CW_W = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] ir_opcode,
  output logic [CW_W-1:0] con,
  output STATE_t          state,
  output logic            halted
);

  logic hlt_now;
  logic freeze;

  assign hlt_now = (state == T4) && (ir_opcode == OP_W'(HLT));
  // Freezing on the same edge that sets halted keeps the ring parked at T4.
  assign freeze  = halted | hlt_now;

  sap_ring_counter u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .state  (state)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (hlt_now) begin
      halted <= 1'b1;
    end
  end

  // Reset is folded in combinationally so no fetch word leaks out while rst_n is low.
  always_comb begin
    con = CW_NOP;
    if (rst_n && !halted) begin
      case (state)
        T1: con = CW_FETCH1;
        T2: con = CW_FETCH2;
        T3: con = CW_FETCH3;
        T4: begin
          case (ir_opcode)
            LDA, ADD, SUB: con = CW_LDA4;
            OUT:           con = CW_OUT4;
            default:       con = CW_NOP;
          endcase
        end
        T5: begin
          case (ir_opcode)
            LDA:      con = CW_LDA5;
            ADD, SUB: con = CW_ADD5;
            default:  con = CW_NOP;
          endcase
        end
        T6: begin
          case (ir_opcode)
            ADD:     con = CW_ADD6;
            SUB:     con = CW_SUB6;
            default: con = CW_NOP;
          endcase
        end
        default: con = CW_NOP;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer with hand-computed control words.
module tb_sap_controller_sequencer;
  import sap_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ir_opcode;
  logic [11:0] con;
  STATE_t      state;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  sap_controller_sequencer #(.OP_W(4), .CW_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_opcode (ir_opcode),
    .con       (con),
    .state     (state),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step to the next T-state and settle away from both edges.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run_instr(input string name, input logic [3:0] op,
                           input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    ir_opcode = 4'hF;
    chk({name, "_t1_state"}, 32'(state), 32'(6'b000001));
    chk({name, "_t1_con"}, 32'(con), 32'h5E3);
    tick();
    chk({name, "_t2_con"}, 32'(con), 32'hBE3);
    ir_opcode = 4'h5;
    tick();
    chk({name, "_t3_con"}, 32'(con), 32'h263);
    ir_opcode = op;
    tick();
    chk({name, "_t4_state"}, 32'(state), 32'(6'b001000));
    chk({name, "_t4_con"}, 32'(con), 32'(e4));
    tick();
    chk({name, "_t5_con"}, 32'(con), 32'(e5));
    tick();
    chk({name, "_t6_con"}, 32'(con), 32'(e6));
    tick();
    chk({name, "_wrap_state"}, 32'(state), 32'(6'b000001));
    chk({name, "_wrap_halted"}, 32'(halted), 32'd0);
  endtask

  // Structural invariants sampled on every rising edge.
  always @(posedge clk) begin
    if (mon_en) begin
      automatic int loads = 0;
      automatic int drvs  = 0;
      loads = int'(!con[9]) + int'(!con[7]) + int'(!con[5]) + int'(!con[1]) + int'(!con[0]);
      drvs  = int'(con[10]) + int'(!con[8]) + int'(!con[6]) + int'(con[4]) + int'(con[2]);
      chk("mon_onehot", 32'($countones(state)), 32'd1);
      chk("mon_loads_le1", 32'(loads <= 1), 32'd1);
      chk("mon_drivers_le1", 32'(drvs <= 1), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ir_opcode = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(6'b000001));
    chk("rst_con", 32'(con), 32'h3E3);
    chk("rst_halted", 32'(halted), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;

    run_instr("lda", 4'b0000, 12'h1A3, 12'h2C3, 12'h3E3);
    run_instr("add", 4'b0001, 12'h1A3, 12'h2E1, 12'h3C7);
    run_instr("sub", 4'b0010, 12'h1A3, 12'h2E1, 12'h3CF);
    run_instr("out", 4'b1110, 12'h3F2, 12'h3E3, 12'h3E3);
    run_instr("undef", 4'b0101, 12'h3E3, 12'h3E3, 12'h3E3);

    // Halt: fetch, then park at T4 for good.
    chk("hlt_t1_con", 32'(con), 32'h5E3);
    tick();
    tick();
    ir_opcode = 4'b1111;
    tick();
    chk("hlt_t4_con", 32'(con), 32'h3E3);
    chk("hlt_t4_halted_pre", 32'(halted), 32'd0);
    tick();
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_state", 32'(state), 32'(6'b001000));
    for (int i = 0; i < 20; i++) begin
      ir_opcode = 4'(i);
      tick();
      chk("hlt_hold_state", 32'(state), 32'(6'b001000));
      chk("hlt_hold_con", 32'(con), 32'h3E3);
      chk("hlt_hold_halted", 32'(halted), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    chk("hlt_rst_state", 32'(state), 32'(6'b000001));
    chk("hlt_rst_con", 32'(con), 32'h3E3);
    rst_n = 1'b1;
    #1;
    chk("hlt_restart_con", 32'(con), 32'h5E3);
    tick();
    chk("hlt_restart_t2", 32'(con), 32'hBE3);
    tick();
    tick();
    tick();
    tick();
    tick();

    // Reset in the middle of ADD T5 must drop the control word immediately.
    chk("mid_t1_con", 32'(con), 32'h5E3);
    tick();
    tick();
    ir_opcode = 4'b0001;
    tick();
    tick();
    chk("mid_t5_con", 32'(con), 32'h2E1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_con", 32'(con), 32'h3E3);
    chk("mid_rst_state", 32'(state), 32'(6'b000001));
    rst_n = 1'b1;
    #1;
    chk("mid_release_con", 32'(con), 32'h5E3);
    tick();
    chk("mid_after_t2", 32'(con), 32'hBE3);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
